// File: rtl/pipe_pkg.sv
// Shared definitions for the memory-access stage: access-size encodings and
// the data-memory request FSM state type.
package pipe_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } memState_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for stores and zero-extended lane extraction for loads,
// driven by the access size and the low two address bits.
module mem_lane_align
   import pipe_pkg::*;
(
   input  logic [1:0]  i_size,
   input  logic [1:0]  i_addrLo,
   input  logic [31:0] i_storeData,
   input  logic [31:0] i_rdata,
   output logic [3:0]  o_be,
   output logic [31:0] o_wdata,
   output logic [31:0] o_loadData
);

   logic [31:0] w_rdataShifted;

   assign w_rdataShifted = i_rdata >> {i_addrLo, 3'b000};

   // Size 2'b11 falls into the word arm.
   always_comb begin
      o_be       = 4'b1111;
      o_wdata    = i_storeData;
      o_loadData = i_rdata;
      case (i_size)
         SZ_BYTE: begin
            o_be       = 4'b0001 << i_addrLo;
            o_wdata    = {4{i_storeData[7:0]}};
            o_loadData = {24'h000000, w_rdataShifted[7:0]};
         end
         SZ_HALF: begin
            o_be       = i_addrLo[1] ? 4'b1100 : 4'b0011;
            o_wdata    = {2{i_storeData[15:0]}};
            o_loadData = {16'h0000, (i_addrLo[1] ? i_rdata[31:16] : i_rdata[15:0])};
         end
         default: begin
            o_be       = 4'b1111;
            o_wdata    = i_storeData;
            o_loadData = i_rdata;
         end
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: E->M register, req/ack data-memory FSM and lane alignment.
// Optional ack watchdog enabled by defining MEM_TIMEOUT_EN.
module mem_stage
   import pipe_pkg::*;
#(
   parameter int AW             = 32,
   parameter int DW             = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          PCSrcE,
   input  logic          RegWriteE,
   input  logic          MemtoRegE,
   input  logic          MemWriteE,
   input  logic [1:0]    SizeE,
   input  logic [3:0]    RdE,
   input  logic [DW-1:0] ALUResultE,
   input  logic [DW-1:0] WriteDataE,
   output logic          PCSrcM,
   output logic          RegWriteM,
   output logic          MemtoRegM,
   output logic          MemWriteM,
   output logic [3:0]    RdM,
   output logic [DW-1:0] ALUResultM,
   output logic [DW-1:0] ReadDataM,
   output logic          stallM,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [3:0]    mem_be,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_ack,
   output logic          mem_err
);

   memState_t     r_state;
   memState_t     w_nextState;
   logic          r_pcSrc;
   logic          r_regWrite;
   logic          r_memtoReg;
   logic          r_memWrite;
   logic [1:0]    r_size;
   logic [3:0]    r_rd;
   logic [DW-1:0] r_aluResult;
   logic [DW-1:0] r_storeData;
   logic [DW-1:0] r_readData;
   logic          r_memReq;
   logic          w_advance;
   logic          w_memOpE;
   logic          w_memOpM;
   logic          w_ackTake;
   logic [3:0]    w_be;
   logic [DW-1:0] w_wdata;
   logic [DW-1:0] w_loadData;
`ifdef MEM_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0] r_toCnt;
   logic            r_memErr;
   logic            w_timeout;
`endif

   assign w_advance = (r_state != ST_ACCESS);
   assign w_memOpE  = MemtoRegE | MemWriteE;
   assign w_memOpM  = r_memtoReg | r_memWrite;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= ST_IDLE;
      else        r_state <= w_nextState;
   end

   // Any non-ACCESS state advances; ACCESS leaves only on ack (or watchdog expiry).
   always_comb begin
      w_nextState = r_state;
      w_ackTake   = 1'b0;
`ifdef MEM_TIMEOUT_EN
      w_timeout   = 1'b0;
`endif
      if (w_advance) begin
         w_nextState = w_memOpE ? ST_ACCESS : ST_IDLE;
      end else if (mem_ack) begin
         w_nextState = ST_DONE;
         w_ackTake   = 1'b1;
      end
`ifdef MEM_TIMEOUT_EN
      else if (r_toCnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
         w_nextState = ST_DONE;
         w_timeout   = 1'b1;
      end
`endif
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pcSrc     <= 1'b0;
         r_regWrite  <= 1'b0;
         r_memtoReg  <= 1'b0;
         r_memWrite  <= 1'b0;
         r_size      <= 2'b00;
         r_rd        <= 4'h0;
         r_aluResult <= '0;
         r_storeData <= '0;
         r_readData  <= '0;
         r_memReq    <= 1'b0;
      end else if (w_advance) begin
         r_pcSrc     <= PCSrcE;
         r_regWrite  <= RegWriteE;
         r_memtoReg  <= MemtoRegE;
         r_memWrite  <= MemWriteE;
         r_size      <= SizeE;
         r_rd        <= RdE;
         r_aluResult <= ALUResultE;
         r_storeData <= WriteDataE;
         r_memReq    <= w_memOpE;
      end else if (w_ackTake) begin
         r_memReq <= 1'b0;
         if (r_memtoReg) r_readData <= w_loadData;
      end
`ifdef MEM_TIMEOUT_EN
      else if (w_timeout) begin
         r_memReq   <= 1'b0;
         r_readData <= '0;
      end
`endif
   end

`ifdef MEM_TIMEOUT_EN
   // Watchdog counts un-acked ACCESS cycles; the error flag is sticky until reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_toCnt  <= '0;
         r_memErr <= 1'b0;
      end else begin
         if (w_advance)     r_toCnt <= '0;
         else if (!mem_ack) r_toCnt <= r_toCnt + 1'b1;
         if (w_timeout)     r_memErr <= 1'b1;
      end
   end
   assign mem_err = r_memErr;
`else
   assign mem_err = 1'b0;
`endif

   mem_lane_align u_align (
      .i_size      (r_size),
      .i_addrLo    (r_aluResult[1:0]),
      .i_storeData (r_storeData),
      .i_rdata     (mem_rdata),
      .o_be        (w_be),
      .o_wdata     (w_wdata),
      .o_loadData  (w_loadData)
   );

   // Lane enables are gated so a cleared (non-memory) M stage drives all zeros.
   assign mem_be     = w_memOpM ? w_be : 4'b0000;
   assign mem_wdata  = w_wdata;
   assign mem_we     = r_memWrite;
   assign mem_addr   = {r_aluResult[AW-1:2], 2'b00};
   assign mem_req    = r_memReq;
   assign stallM     = (r_state == ST_ACCESS);
   assign PCSrcM     = r_pcSrc;
   assign RegWriteM  = r_regWrite;
   assign MemtoRegM  = r_memtoReg;
   assign MemWriteM  = r_memWrite;
   assign RdM        = r_rd;
   assign ALUResultM = r_aluResult;
   assign ReadDataM  = r_readData;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage ARM pipeline. Sits between execute and writeback.
- Contains the E→M pipeline register and the data-memory request FSM (req/ack handshake, variable latency).
- Handles byte/halfword lane steering for stores and extraction for loads.
- Asserts a pipeline stall while an access is outstanding, then hands aligned load data and M-stage controls to writeback.

Parameters:
- AW, 32, data-memory address width.
- DW, 32, data width; fixed at 32, four byte lanes.
- TIMEOUT_CYCLES, 16, ack watchdog limit; used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- PCSrcE, RegWriteE, MemtoRegE, MemWriteE  in  1 each  execute-stage controls.
- SizeE  in  2  access size: 00 byte, 01 halfword, 10 word (11 treated as word).
- RdE  in  4  destination register.
- ALUResultE  in  32  address, or result for non-memory ops.
- WriteDataE  in  32  store data, right-justified.
- PCSrcM, RegWriteM, MemtoRegM, MemWriteM  out  1 each  registered controls to writeback.
- RdM  out  4  registered destination register.
- ALUResultM  out  32  registered ALU result.
- ReadDataM  out  32  aligned, zero-extended load data.
- stallM  out  1  freeze fetch/decode/execute and hold this stage.
- mem_req  out  1  memory request, registered.
- mem_we  out  1  write enable.
- mem_addr  out  AW  word-aligned address; bits [1:0] always 0.
- mem_be  out  4  byte-lane enables.
- mem_wdata  out  32  lane-steered store data.
- mem_rdata  in  32  memory read data; valid with mem_ack.
- mem_ack  in  1  access complete; sampled only while mem_req=1.
- mem_err  out  1  sticky timeout flag; tied 0 without MEM_TIMEOUT_EN.

Behaviour:
- Reset (reset=0, async): all M registers, ReadDataM, mem_* outputs and mem_err cleared to 0; FSM goes to IDLE.
- Reset mid-access abandons the access with no retry.
- M register: captures all E inputs on a rising edge when stallM=0; holds them when stallM=1.
- A captured op with MemtoReg|MemWrite set is a memory op.
- FSM states: IDLE, ACCESS, DONE.
  - Any state, on an advancing edge (stallM=0): next state is ACCESS if the incoming E op is a memory op, else IDLE.
  - ACCESS: mem_req=1; on mem_ack=1, capture the extracted load into ReadDataM, deassert mem_req, go to DONE. Otherwise stay in ACCESS.
  - DONE: mem_req=0; stage advances at the end of the cycle.
- stallM = (state==ACCESS). It is combinational from state only, with no mem_ack→stallM path.
- Latency: non-memory op occupies M for 1 cycle. Memory op occupies M for N+1 cycles, where N = cycles in ACCESS up to and including the ack.
- Zero-wait memory (ack in the first ACCESS cycle) gives 2 cycles.
- Request outputs:
  - mem_we = MemWriteM.
  - mem_addr = {ALUResultM[AW-1:2], 2'b00}.
  - All mem_* outputs are stable for the whole ACCESS interval.
- Store steering, with a = ALUResultM[1:0]:
  - byte: be = 1<<a; data replicated to all 4 lanes.
  - halfword: be = 0011 if a[1]=0, else 1100; a[0] ignored; data replicated to both halves.
  - word: be = 1111; a ignored.
- Load extraction:
  - byte: lane a, zero-extended.
  - halfword: half a[1], zero-extended.
  - word: mem_rdata unchanged.
- Non-load ops: ReadDataM keeps its previous value; writeback ignores it when MemtoRegM=0.
- Back-to-back memory ops: DONE advances straight to ACCESS with no idle cycle. mem_req drops for exactly the DONE cycle.
- mem_ack while mem_req=0 is ignored.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- With the macro:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle without ack.
  - When it reaches TIMEOUT_CYCLES, the FSM forces DONE, ReadDataM=0, and mem_err=1.
  - mem_err is sticky until reset; a store counts as not performed.
- Without the macro: no counter, mem_err=0, and ACCESS waits indefinitely.

Decomposition:
- Shared package (pipe_pkg): size encodings SZ_BYTE/SZ_HALF/SZ_WORD and the FSM state enum.
- Sub-module mem_lane_align: combinational store steering (be/wdata) and load extraction from size and a[1:0].
- The FSM and pipeline register stay in mem_stage.

Test Plan:
- Non-memory op, ALUResultE=0x1234: ALUResultM=0x1234 one cycle later; stallM stays 0; mem_req never asserted.
- Word load at 0x100, ack on the 3rd ACCESS cycle, rdata=0xDEADBEEF:
  - mem_addr=0x100, be=1111, stallM=1 for 3 cycles.
  - ReadDataM=0xDEADBEEF in DONE.
- Byte store 0xA5 at 0x203, zero-wait ack: be=1000, wdata=0xA5A5A5A5, mem_we=1, total M occupancy 2 cycles.
- Halfword load at 0x102, rdata=0x8765_4321: ReadDataM=0x00008765.
- Back-to-back load then store: mem_req low exactly one cycle (DONE) between requests; upstream held correctly throughout.
- Reset asserted mid-ACCESS: all outputs 0 immediately (async); mem_req=0.
- With MEM_TIMEOUT_EN, no ack: exit after 16 cycles; mem_err=1 stays set; ReadDataM=0.
